shift_arbiter: RTL

Shares one 32-bit barrel shifter datapath between two requesters: the pipeline ALU shift path (requester 0) and the multi-cycle helper unit (requester 1). It accepts one shift command at a time through a valid/ready handshake and arbitrates between the requesters. It drives the shifter inputs from registered operands, captures the result and flags, and returns them on a single response channel tagged with the requester ID. The parent instantiates the shifter datapath next to this block.

---
 rtl/shift_pkg.sv | 19 +
 rtl/rr_arb2.sv | 48 ++++
 rtl/shift_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter slice: shifter widths, op
// encodings seen on the aluc bits, and the sequencing state type.
package shift_pkg;

  localparam int SH_W     = 32;
  localparam int SH_AMT_W = 5;

  // Op encodings on {aluc1, aluc0}; 2'b11 also shifts left.
  localparam logic [1:0] SH_SRA = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SLL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter with a one-bit priority pointer.
//   clk, rst_n  : clock, asynchronous active-low reset (pointer -> 0)
//   req[1:0]    : request vector, bit N = requester N valid
//   en          : grants are only issued while en is high
//   update      : a grant was taken this cycle; pointer moves to the loser
//   grant[1:0]  : one-hot grant (zero when en is low or nothing requests)
//   grant_id    : index of the winning requester
module rr_arb2
  import shift_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       update,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr;
  logic win;

  always_comb begin
    win = 1'b0;
    if (req == 2'b10) begin
      win = 1'b1;
    end else if (req == 2'b11) begin
      // Fixed-priority mode ignores the pointer and always favours 0.
      win = FAIR ? ptr : 1'b0;
    end
    grant_id = win;
    grant    = 2'b00;
    if (en && (req != 2'b00)) begin
      grant = win ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~win;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one external barrel shifter between two requesters. Accepts one
// command at a time, drives the shifter from registered operands, captures
// result and flags and returns them tagged with the requester id.
//
//   state | meaning
//   IDLE  | ready follows grant; accept a command -> EXEC
//   EXEC  | shifter driven from operand regs; latch result/flags -> RESP
//   RESP  | rsp_valid high; leave to IDLE when rsp_ready
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reqN_valid/ready/op/amt/data : command channel of requester N (N=0,1)
//   rsp_valid/ready/id/result  : response channel
//   rsp_zero/carry/negative/overflow : captured shifter flags
//   sh_a, sh_b, sh_aluc1/0     : registered operands to the shifter
//   sh_result, sh_zero/carry/negative/overflow : shifter outputs
//   busy                       : high whenever not IDLE
module shift_arbiter
  import shift_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [1:0]          req0_op,
  input  logic [SH_AMT_W-1:0] req0_amt,
  input  logic [SH_W-1:0]     req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [1:0]          req1_op,
  input  logic [SH_AMT_W-1:0] req1_amt,
  input  logic [SH_W-1:0]     req1_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [SH_W-1:0]     rsp_result,
  output logic                rsp_zero,
  output logic                rsp_carry,
  output logic                rsp_negative,
  output logic                rsp_overflow,
  output logic [SH_W-1:0]     sh_a,
  output logic [SH_W-1:0]     sh_b,
  output logic                sh_aluc1,
  output logic                sh_aluc0,
  input  logic [SH_W-1:0]     sh_result,
  input  logic                sh_zero,
  input  logic                sh_carry,
  input  logic                sh_negative,
  input  logic                sh_overflow,
  output logic                busy
);

  state_t              state;
  logic [1:0]          grant;
  logic                grant_id;
  logic                accept;
  logic                pend_id;
  logic [1:0]          op_sel;
  logic [SH_AMT_W-1:0] amt_sel;
  logic [SH_W-1:0]     data_sel;

  rr_arb2 #(.FAIR(FAIR)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({req1_valid, req0_valid}),
    .en       (state == IDLE),
    .update   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Grant already implies valid, so any grant bit is an acceptance. Ready is
  // masked by rst_n so it reads low while reset is held.
  assign accept     = grant[0] | grant[1];
  assign req0_ready = grant[0] & rst_n;
  assign req1_ready = grant[1] & rst_n;

  assign op_sel   = grant_id ? req1_op   : req0_op;
  assign amt_sel  = grant_id ? req1_amt  : req0_amt;
  assign data_sel = grant_id ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      pend_id      <= 1'b0;
      sh_a         <= '0;
      sh_b         <= '0;
      sh_aluc1     <= 1'b0;
      sh_aluc0     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_negative <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sh_a                 <= {{(SH_W-SH_AMT_W){1'b0}}, amt_sel};
            sh_b                 <= data_sel;
            {sh_aluc1, sh_aluc0} <= op_sel;
            pend_id              <= grant_id;
            busy                 <= 1'b1;
            state                <= EXEC;
          end
        end
        EXEC: begin
          rsp_result   <= sh_result;
          rsp_zero     <= sh_zero;
          rsp_carry    <= sh_carry;
          rsp_negative <= sh_negative;
          rsp_overflow <= sh_overflow;
          rsp_id       <= pend_id;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
